// File: rtl/key_debounce_onehot8.sv
// key_debounce_onehot8: synchronise and debounce 8 push-buttons, accept only a stable single key as one-hot
module key_debounce_onehot8 #(
  parameter int CNT_MAX = 1000000,
  parameter int CNT_W   = 20
) (
  input  logic       iClk,
  input  logic       iRst_n,
  input  logic [7:0] iKey,
  output logic [7:0] oData,
  output logic       oValid,
  output logic       oErr,
  output logic       oBusy
);
  typedef enum logic [1:0] {IDLE, DEBOUNCE, HOLD, RELEASE} stateT;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);
  stateT state, stateNext;
  logic [7:0] s1, ks, snap, snapNext, dataNext;
  logic [CNT_W-1:0] cnt, cntNext;
  logic validNext, errNext, oneHot;
  assign oneHot = (snap & (snap - 8'd1)) == 8'h00;
  always_ff @(posedge iClk or negedge iRst_n)
    if (!iRst_n) begin
      s1     <= '0;
      ks     <= '0;
      state  <= IDLE;
      snap   <= '0;
      cnt    <= '0;
      oData  <= '0;
      oValid <= 1'b0;
      oErr   <= 1'b0;
      oBusy  <= 1'b0;
    end else begin
      s1     <= iKey;
      ks     <= s1;
      state  <= stateNext;
      snap   <= snapNext;
      cnt    <= cntNext;
      oData  <= dataNext;
      oValid <= validNext;
      oErr   <= errNext;
      oBusy  <= stateNext != IDLE;
    end
  always_comb begin
    stateNext = state;
    snapNext  = snap;
    cntNext   = cnt;
    dataNext  = oData;
    validNext = 1'b0;
    errNext   = 1'b0;
    case (state)
      IDLE:
        if (ks != 8'h00) begin
          snapNext  = ks;
          cntNext   = '0;
          stateNext = DEBOUNCE;
        end
      DEBOUNCE:
        if (ks != snap) begin
          cntNext   = '0;
          stateNext = IDLE;
        end else if (cnt != CNT_LAST) cntNext = cnt + 1'b1;
        else begin
          validNext = oneHot;
          errNext   = !oneHot;
          dataNext  = oneHot ? snap : oData;
          stateNext = HOLD;
        end
      HOLD:
        if (ks == 8'h00) begin
          cntNext   = '0;
          stateNext = RELEASE;
        end
      RELEASE:
        if (ks != 8'h00) begin
          cntNext   = '0;
          stateNext = HOLD;
        end else if (cnt == CNT_LAST) stateNext = IDLE;
        else cntNext = cnt + 1'b1;
    endcase
  end
endmodule
